// File: rtl/instr_format_queue.sv
// instr_format_queue
//   Instruction buffer between fetch and decode. Each instruction is classified
//   on entry (2-bit format type, illegal flag) and stored alongside it. Entries
//   leave in order over a valid/ready handshake. Once a HALT (opcode 00000) is
//   accepted, intake stays frozen until flush or reset.
//
//   Optional feature: define FMT_STATS_EN to add per-type saturating counters
//   of accepted instructions on stat_cnt (type t at [t*CNT_W +: CNT_W]).
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   flush                 sync discard of entries and halt lock
//   in_valid/in_ready     fetch handshake, in_instr payload
//   out_valid/out_ready   decode handshake, out_instr/out_type/out_illegal payload
//   count                 occupied entries
//   halt_lock             HALT accepted, intake frozen
//   stat_cnt              per-type accepted counts (FMT_STATS_EN only)
module instr_format_queue #(
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_W-1:0]       in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INSTR_W-1:0]       out_instr,
  output logic [1:0]               out_type,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     halt_lock
`ifdef FMT_STATS_EN
  ,
  output logic [4*CNT_W-1:0]       stat_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  logic [DEPTH-1:0][INSTR_W-1:0] mem_instr_q;
  logic [DEPTH-1:0][1:0]         mem_type_q;
  logic [DEPTH-1:0]              mem_ill_q;
  logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                 count_q, count_d;
  logic                          halt_q, halt_d;

  logic [4:0] opc;
  logic [1:0] in_type;
  logic       in_ill;
  logic       push, pop;

  // Format decode; every 5-bit opcode maps to exactly one type.
  always_comb begin
    opc     = in_instr[INSTR_W-1 -: 5];
    in_type = 2'd0;
    in_ill  = 1'b0;
    case (opc) inside
      5'b00010, 5'b00011:                          in_ill  = 1'b1;
      [5'b01000:5'b01011], [5'b10100:5'b10111],
      5'b10000, 5'b10001, 5'b10011:                in_type = 2'd1;
      5'b11000, 5'b10010, 5'b00101, 5'b00111,
      [5'b01100:5'b01111]:                         in_type = 2'd2;
      [5'b11001:5'b11111]:                         in_type = 2'd3;
      default:                                     in_type = 2'd0;
    endcase
  end

  // flush gates in_ready, so a push can never coincide with a flush.
  assign in_ready  = (count_q < CW'(DEPTH)) && !halt_q && !flush;
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    halt_d   = halt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      halt_d   = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (push && opc == 5'b00000) halt_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_instr_q <= '0;
      mem_type_q  <= '0;
      mem_ill_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      halt_q      <= 1'b0;
    end else begin
      if (push) begin
        mem_instr_q[wr_ptr_q] <= in_instr;
        mem_type_q[wr_ptr_q]  <= in_type;
        mem_ill_q[wr_ptr_q]   <= in_ill;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      halt_q   <= halt_d;
    end
  end

  // Stale storage after flush is hidden by out_valid, not cleared.
  assign out_instr   = mem_instr_q[rd_ptr_q];
  assign out_type    = mem_type_q[rd_ptr_q];
  assign out_illegal = mem_ill_q[rd_ptr_q];
  assign count       = count_q;
  assign halt_lock   = halt_q;

`ifdef FMT_STATS_EN
  logic [3:0][CNT_W-1:0] stat_q;

  // Survives flush; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else if (push && stat_q[in_type] != '1) begin
      stat_q[in_type] <= stat_q[in_type] + CNT_W'(1);
    end
  end

  assign stat_cnt = stat_q;
`endif

endmodule

// File: tb/tb_instr_format_queue.sv
module tb_instr_format_queue;

  localparam int INSTR_W = 16;
  localparam int DEPTH   = 4;
`ifdef FMT_STATS_EN
  localparam int CNT_W   = 2;
`else
  localparam int CNT_W   = 16;
`endif

  logic                 clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [INSTR_W-1:0]   in_instr, out_instr;
  logic [1:0]           out_type;
  logic                 out_illegal, halt_lock;
  logic [$clog2(DEPTH):0] count;
`ifdef FMT_STATS_EN
  logic [4*CNT_W-1:0]   stat_cnt;
`endif

  instr_format_queue #(.INSTR_W(INSTR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_type(out_type), .out_illegal(out_illegal),
    .count(count), .halt_lock(halt_lock)
`ifdef FMT_STATS_EN
    , .stat_cnt(stat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic do_flush();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // Reference classification written from the opcode table as numeric ranges.
  function automatic void ref_class(input logic [15:0] ins, output logic [1:0] t, output logic ill);
    int o;
    o = int'(ins[15:11]);
    ill = (o == 2 || o == 3);
    if (o <= 4 || o == 6)                                 t = 2'd0;
    else if ((o >= 8 && o <= 11) || (o >= 20 && o <= 23) ||
             o == 16 || o == 17 || o == 19)               t = 2'd1;
    else if (o >= 25)                                     t = 2'd3;
    else                                                  t = 2'd2;
  endfunction

  typedef struct { logic [15:0] instr; logic [1:0] t; logic ill; } vec_t;
  typedef struct { logic [15:0] instr; logic [1:0] t; logic ill; } ent_t;

  vec_t vecs[20];
  ent_t mq[$];
  bit   mhalt;
  int   mstat[4];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs = '{
      '{16'h0000, 2'd0, 1'b0}, '{16'h0800, 2'd0, 1'b0}, '{16'h1000, 2'd0, 1'b1},
      '{16'h1800, 2'd0, 1'b1}, '{16'h2000, 2'd0, 1'b0}, '{16'h2800, 2'd2, 1'b0},
      '{16'h3000, 2'd0, 1'b0}, '{16'h3800, 2'd2, 1'b0}, '{16'h4000, 2'd1, 1'b0},
      '{16'h5800, 2'd1, 1'b0}, '{16'h6000, 2'd2, 1'b0}, '{16'h7800, 2'd2, 1'b0},
      '{16'h8000, 2'd1, 1'b0}, '{16'h9000, 2'd2, 1'b0}, '{16'h9800, 2'd1, 1'b0},
      '{16'hA000, 2'd1, 1'b0}, '{16'hB8FF, 2'd1, 1'b0}, '{16'hC000, 2'd2, 1'b0},
      '{16'hC800, 2'd3, 1'b0}, '{16'hF812, 2'd3, 1'b0}
    };

    // Reset state
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_type", out_type, 0);
    chk("rst_out_illegal", out_illegal, 0);
    chk("rst_count", count, 0);
    chk("rst_halt_lock", halt_lock, 0);
    chk("rst_in_ready", in_ready, 1);

    // Fill with four types, then drain in order
    begin
      logic [15:0] seq[4];
      logic [1:0]  st[4];
      seq = '{16'hD8E0, 16'h4123, 16'h6004, 16'h2005};
      st  = '{2'd3, 2'd1, 2'd2, 2'd0};
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin in_instr = seq[i]; tick(); end
      in_valid = 1'b0;
      chk("fill_count", count, 4);
      chk("fill_in_ready", in_ready, 0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        chk("drain_type", out_type, st[i]);
        chk("drain_instr", out_instr, seq[i]);
        tick();
      end
      out_ready = 1'b0;
      chk("drain_empty", out_valid, 0);
    end

    // Classification table
    foreach (vecs[i]) begin
      do_flush();
      in_valid = 1'b1; in_instr = vecs[i].instr;
      tick();
      in_valid = 1'b0;
      chk("tbl_valid", out_valid, 1);
      chk("tbl_type", out_type, vecs[i].t);
      chk("tbl_illegal", out_illegal, vecs[i].ill);
    end

    // Full queue with simultaneous pop and push offer
    do_flush();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin in_instr = 16'h4000 + 16'(i); tick(); end
    in_instr = 16'h4777; out_ready = 1'b1;
    chk("full_in_ready", in_ready, 0);
    tick();
    chk("full_pop_count", count, 3);
    chk("full_pop_head", out_instr, 16'h4001);

    // Streaming throughput
    do_flush();
    in_valid = 1'b1; out_ready = 1'b1; in_instr = 16'h4100;
    #1 chk("stream_first_valid", out_valid, 0);
    for (int k = 1; k < 7; k++) begin
      tick();
      chk("stream_valid", out_valid, 1);
      chk("stream_count", count, 1);
      chk("stream_instr", out_instr, 16'h4100 + 16'(k - 1));
      in_instr = 16'h4100 + 16'(k);
    end
    in_valid = 1'b0; out_ready = 1'b0;

    // HALT lock holds through drain, released by flush
    do_flush();
    in_valid = 1'b1; in_instr = 16'h0800; tick();
    in_instr = 16'h0000; tick();
    in_instr = 16'h4000;
    chk("halt_set", halt_lock, 1);
    chk("halt_in_ready", in_ready, 0);
    out_ready = 1'b1; tick(); tick();
    chk("halt_drained_count", count, 0);
    chk("halt_after_drain", halt_lock, 1);
    chk("halt_in_ready_drained", in_ready, 0);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
    #1 chk("flush_in_ready", in_ready, 0);
    tick(); flush = 1'b0; #1;
    chk("halt_cleared", halt_lock, 0);
    chk("flush_in_ready_after", in_ready, 1);
    chk("flush_count", count, 0);

    // Flush wins over push and pop
    in_valid = 1'b1; in_instr = 16'h4000; tick(); in_instr = 16'h4001; tick();
    flush = 1'b1; out_ready = 1'b1; in_instr = 16'h4002; tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; #1;
    chk("flush_mix_count", count, 0);
    chk("flush_mix_valid", out_valid, 0);

    // Reset mid-stream is immediate
    in_valid = 1'b1; in_instr = 16'hC800; tick(); tick();
    #2 rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_instr", out_instr, 0);
    chk("arst_type", out_type, 0);
    chk("arst_in_ready", in_ready, 1);
    do_reset();

`ifdef FMT_STATS_EN
    // Saturating stats, untouched by flush
    in_valid = 1'b1; out_ready = 1'b1; in_instr = 16'hD8E0;
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("stat_r_sat", stat_cnt[3*CNT_W +: CNT_W], 3);
    chk("stat_j_zero", stat_cnt[0 +: CNT_W], 0);
    do_flush(); #1;
    chk("stat_after_flush", stat_cnt[3*CNT_W +: CNT_W], 3);
    do_reset();
`endif

    // Randomized run against a queue model
    mq.delete(); mhalt = 0;
    for (int t = 0; t < 4; t++) mstat[t] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit m_push, m_pop;
      ent_t e;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_instr  = 16'($urandom);
      #1;
      chk("rnd_in_ready", in_ready, (mq.size() < DEPTH) && !mhalt && !flush);
      chk("rnd_count", count, mq.size());
      chk("rnd_out_valid", out_valid, mq.size() != 0);
      chk("rnd_halt", halt_lock, mhalt);
      if (mq.size() != 0) begin
        chk("rnd_out_instr", out_instr, mq[0].instr);
        chk("rnd_out_type", out_type, mq[0].t);
        chk("rnd_out_illegal", out_illegal, mq[0].ill);
      end
`ifdef FMT_STATS_EN
      for (int t = 0; t < 4; t++) chk("rnd_stat", stat_cnt[t*CNT_W +: CNT_W], mstat[t]);
`endif
      m_push = in_valid && (mq.size() < DEPTH) && !mhalt && !flush;
      m_pop  = out_ready && (mq.size() != 0);
      e.instr = in_instr;
      ref_class(in_instr, e.t, e.ill);
      if (m_push && mstat[e.t] < (1 << CNT_W) - 1) mstat[e.t]++;
      if (flush) begin
        mq.delete(); mhalt = 0;
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          mq.push_back(e);
          if (in_instr[15:11] == 5'd0) mhalt = 1;
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
